risc_v_mike_mem_arbiter: RTL and testbench
==========================================

// Module: risc_v_mike_mem_arbiter
// PURPOSE
// - Two-requester arbiter for the unified memory bus. Requester 0 is the multicycle core
//   (fetch and load/store share one port). Requester 1 is a DMA/program loader.
// - Serialises requests onto one single-port memory, returns read data to the issuer
//   and stalls the core FSM while the DMA owns the bus.
// - Sits between the core's mem-bus address/data mux and risc_v_mem_ctrl.
// PARAMETERS
// - ADDR_W     32  address width, both requesters and the memory side
// - DATA_W     32  data width
// - MAX_BURST  8   max consecutive grants to one requester while the other waits (>=1)
// PORTS
// - clk          in   1       system clock, rising edge
// - rst          in   1       asynchronous, active-low reset
// - core_req     in   1       core access request, level
// - core_we      in   1       1=write, 0=read
// - core_addr    in   ADDR_W  core byte address
// - core_wdata   in   DATA_W  core write data
// - core_gnt     out  1       core access accepted this cycle
// - core_stall   out  1       core_req & ~core_gnt; core FSM holds its state
// - core_rvalid  out  1       core read data valid, 1 cycle after the granted read
// - core_rdata   out  DATA_W  core read data
// - dma_req      in   1       DMA access request, level
// - dma_we       in   1       1=write, 0=read
// - dma_lock     in   1       DMA asks to keep the bus on the next cycle
// - dma_addr     in   ADDR_W  DMA byte address
// - dma_wdata    in   DATA_W  DMA write data
// - dma_gnt      out  1       DMA access accepted this cycle
// - dma_rvalid   out  1       DMA read data valid, 1 cycle after the granted read
// - dma_rdata    out  DATA_W  DMA read data
// - mem_re       out  1       memory read strobe
// - mem_we       out  1       memory write strobe
// - mem_addr     out  ADDR_W  memory address
// - mem_wdata    out  DATA_W  memory write data
// - mem_rdata    in   DATA_W  memory read data, valid 1 cycle after mem_re
// - arb_owner    out  1       registered owner of the last grant (0=core, 1=DMA)
// BEHAVIOUR
// - Reset values: all gnt/rvalid/strobes = 0; rdata = 0; arb_owner = 1 (DMA).
//   Internal state: last_owner = DMA (so the core wins the first tie), burst_cnt = 0,
//   rd_pend = 0.
// - Grant is combinational from req and registered state. At most one gnt per cycle.
//   The request is accepted in the same cycle as its gnt. The requester holds
//   req/we/addr/wdata stable until it sees gnt.
// - Arbitration, evaluated in priority order:
//   a) only one req asserted -> grant it;
//   b) both asserted, last_owner=DMA, dma_lock=1, burst_cnt<MAX_BURST-1 -> DMA;
//   c) both asserted, burst_cnt==MAX_BURST-1 -> grant the other requester;
//   d) both asserted otherwise -> grant the requester that is not last_owner
//      (round-robin).
// - burst_cnt: incremented on a grant to the same requester as last_owner while the
//   other requester is asserted. Cleared on an owner change or when the other
//   requester is idle. Saturates at MAX_BURST-1.
// - Memory side: mem_* is driven from the granted requester's fields. mem_re =
//   gnt & ~we; mem_we = gnt & we. No gnt -> strobes 0, address/data hold last values.
// - Read return: rd_pend/rd_owner are registered on a granted read. Next cycle,
//   mem_rdata is routed to the owner's rdata and its rvalid pulses for 1 cycle.
//   The other rdata holds. Writes produce no rvalid.
// - Back-to-back: a new grant is legal in the cycle the previous read returns
//   (full throughput, 1 access/cycle).
// - Reset mid-read: the pending rvalid is dropped and no stale data is delivered.
// - dma_lock is ignored when dma_req=0. A lock never starves the core beyond MAX_BURST.
// STRUCTURE
// - risc_v_mike_pkg: typedef enum logic {ARB_CORE=1'b0, ARB_DMA=1'b1} t_arb_owner;
//   localparam ARB_MAX_BURST_DEF = 8.
// - Sub-module risc_v_mike_rr_arb2: 2-way round-robin plus burst counter, outputs the
//   grant vector. The top level holds the mux and the read-return pipeline.
// - All flops use asynchronous active-low reset on rst.
// TESTING
// - Reset then core read, core_addr=0x00400000 -> core_gnt same cycle, mem_re=1;
//   next cycle core_rvalid=1, core_rdata=mem_rdata; dma outputs stay 0.
// - Both req at the first cycle after reset -> core granted, then DMA, then core
//   (alternating); core_stall=1 exactly on the DMA cycles.
// - DMA write burst with dma_lock=1 and core_req held -> DMA gets 7 grants
//   (MAX_BURST-1), then core is granted; burst_cnt clears.
// - DMA read granted, then rst low on the next edge -> dma_rvalid stays 0 and
//   arb_owner=1 after release.
// - Core read then DMA read back-to-back, mem_rdata=0xAAAA0001/0xBBBB0002 -> core_rvalid
//   with 0xAAAA0001, then dma_rvalid with 0xBBBB0002, no cross-delivery.
// - Core write only (we=1, wdata=0xDEADBEEF, addr=0x10010000) -> mem_we=1 for 1 cycle,
//   mem_wdata matches, no rvalid.

Source files
------------

// File: rtl/risc_v_mike_pkg.sv
// -----------------------------------------------------------------------------
// risc_v_mike_pkg
// Shared types and constants for the unified memory bus arbiter.
//   t_arb_owner        : bus owner encoding (core / DMA)
//   ARB_MAX_BURST_DEF  : default limit on consecutive grants while the other
//                        requester waits
//   arb_other()        : returns the opposite owner
//   arb_cnt_w()        : width of a counter that reaches max_burst-1 (min 1 bit)
// -----------------------------------------------------------------------------
package risc_v_mike_pkg;

  typedef enum logic {
    ARB_CORE = 1'b0,
    ARB_DMA  = 1'b1
  } t_arb_owner;

  localparam int unsigned ARB_MAX_BURST_DEF = 32'd8;

  function automatic t_arb_owner arb_other(input t_arb_owner owner);
    return (owner == ARB_DMA) ? ARB_CORE : ARB_DMA;
  endfunction

  // A burst limit of 1 still needs a 1-bit counter to keep the vector legal.
  function automatic int unsigned arb_cnt_w(input int unsigned max_burst);
    return (max_burst > 32'd1) ? $clog2(max_burst) : 32'd1;
  endfunction

endpackage

// File: rtl/risc_v_mike_rr_arb2.sv
// -----------------------------------------------------------------------------
// risc_v_mike_rr_arb2
// Two-way round-robin arbiter with a DMA lock and a burst limiter.
// Bit 0 of the request/grant vectors is the core, bit 1 is the DMA.
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   req_i[1:0]    in   level requests {dma, core}
//   lock_i        in   DMA asks to keep the bus (meaningful only with req_i[1])
//   gnt_o[1:0]    out  one-hot (or zero) grant, combinational
//   last_owner_o  out  registered owner of the most recent grant
// -----------------------------------------------------------------------------
module risc_v_mike_rr_arb2
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned MAX_BURST = ARB_MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       lock_i,
  output logic [1:0] gnt_o,
  output t_arb_owner last_owner_o
);

  localparam int unsigned CNT_W = arb_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 32'd1);

  t_arb_owner       last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]       gnt_s;
  t_arb_owner       gnt_owner_s;
  logic             other_req_s;

  // Grant decision: single requester wins outright; under contention a DMA
  // lock extends the DMA run until the burst limit, otherwise strict
  // alternation. The limit case and plain round-robin both hand the bus to
  // whoever did not own it last, so they share one branch.
  always_comb begin
    gnt_s = 2'b00;
    case (req_i)
      2'b01: gnt_s = 2'b01;
      2'b10: gnt_s = 2'b10;
      2'b11: begin
        if ((last_owner_q == ARB_DMA) && lock_i && (burst_cnt_q < BURST_LAST)) begin
          gnt_s = 2'b10;
        end else if (last_owner_q == ARB_DMA) begin
          gnt_s = 2'b01;
        end else begin
          gnt_s = 2'b10;
        end
      end
      default: gnt_s = 2'b00;
    endcase
  end

  // Next owner and burst count. The counter only runs while the same owner
  // keeps winning against a waiting competitor; anything else restarts it.
  always_comb begin
    last_owner_d = last_owner_q;
    burst_cnt_d  = '0;
    gnt_owner_s  = gnt_s[1] ? ARB_DMA : ARB_CORE;
    other_req_s  = gnt_s[1] ? req_i[0] : req_i[1];
    if (gnt_s != 2'b00) begin
      last_owner_d = gnt_owner_s;
      if ((gnt_owner_s == last_owner_q) && other_req_s) begin
        if (burst_cnt_q != BURST_LAST) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end else begin
        burst_cnt_d = '0;
      end
    end else begin
      burst_cnt_d = '0;
    end
  end

  // Arbitration state. Resetting the owner to DMA lets the core win the
  // first contended cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= ARB_DMA;
      burst_cnt_q  <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign gnt_o        = gnt_s;
  assign last_owner_o = last_owner_q;

endmodule

// File: rtl/risc_v_mike_mem_arbiter.sv
// -----------------------------------------------------------------------------
// risc_v_mike_mem_arbiter
// Two-requester arbiter for the unified single-port memory bus.
// Requester 0 is the multicycle core, requester 1 the DMA / program loader.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   core_req/we/addr/wdata            core request (held until core_gnt)
//   core_gnt, core_stall              core accepted / core must hold state
//   core_rvalid, core_rdata           core read return (1 cycle after grant)
//   dma_req/we/lock/addr/wdata        DMA request (held until dma_gnt)
//   dma_gnt                           DMA accepted
//   dma_rvalid, dma_rdata             DMA read return (1 cycle after grant)
//   mem_re/we/addr/wdata, mem_rdata   memory side; rdata valid 1 cycle after re
//   arb_owner                         registered owner of last grant (1=DMA)
// -----------------------------------------------------------------------------
module risc_v_mike_mem_arbiter
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32'd32,
  parameter int unsigned DATA_W    = 32'd32,
  parameter int unsigned MAX_BURST = ARB_MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_owner
);

  logic [1:0]        gnt_s;
  t_arb_owner        last_owner_s;
  logic              any_gnt_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_pend_q, rd_pend_d;
  t_arb_owner        rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  risc_v_mike_rr_arb2 #(
    .MAX_BURST (MAX_BURST)
  ) u_rr_arb2 (
    .clk          (clk),
    .rst          (rst),
    .req_i        ({dma_req, core_req}),
    .lock_i       (dma_lock & dma_req),
    .gnt_o        (gnt_s),
    .last_owner_o (last_owner_s)
  );

  assign core_gnt   = gnt_s[0];
  assign dma_gnt    = gnt_s[1];
  assign core_stall = core_req & ~gnt_s[0];
  assign arb_owner  = last_owner_s;

  // Memory-side mux. Strobes follow the grant in the same cycle; address and
  // write data keep their last driven value when nobody is granted so the
  // bus does not toggle needlessly.
  always_comb begin
    any_gnt_s = |gnt_s;
    if (gnt_s[1]) begin
      sel_we_s    = dma_we;
      sel_addr_s  = dma_addr;
      sel_wdata_s = dma_wdata;
    end else begin
      sel_we_s    = core_we;
      sel_addr_s  = core_addr;
      sel_wdata_s = core_wdata;
    end
    mem_re    = any_gnt_s & ~sel_we_s;
    mem_we    = any_gnt_s & sel_we_s;
    if (any_gnt_s) begin
      mem_addr  = sel_addr_s;
      mem_wdata = sel_wdata_s;
    end else begin
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
    end
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
  end

  // Read-return routing. mem_rdata arrives the cycle after the granted read
  // and is forwarded directly to the issuer; the other port keeps its data.
  always_comb begin
    rd_pend_d = any_gnt_s & ~sel_we_s;
    if (rd_pend_d) begin
      rd_owner_d = gnt_s[1] ? ARB_DMA : ARB_CORE;
    end else begin
      rd_owner_d = rd_owner_q;
    end
    core_rvalid = rd_pend_q & (rd_owner_q == ARB_CORE);
    dma_rvalid  = rd_pend_q & (rd_owner_q == ARB_DMA);
    if (core_rvalid) begin
      core_rdata = mem_rdata;
    end else begin
      core_rdata = core_rdata_q;
    end
    if (dma_rvalid) begin
      dma_rdata = mem_rdata;
    end else begin
      dma_rdata = dma_rdata_q;
    end
    core_rdata_d = core_rdata;
    dma_rdata_d  = dma_rdata;
  end

  // Bus hold registers and the one-deep read pipeline. An asynchronous reset
  // drops any pending return so stale data is never delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= ARB_CORE;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_risc_v_mike_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_risc_v_mike_mem_arbiter
// Directed scenarios plus randomized traffic against a behavioural model of
// the arbiter: who gets the bus, what the memory sees, and where read data
// lands one cycle later.
// -----------------------------------------------------------------------------
module tb_risc_v_mike_mem_arbiter;

  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req, core_we, dma_req, dma_we, dma_lock;
  logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        core_gnt, core_stall, core_rvalid, dma_gnt, dma_rvalid;
  logic        mem_re, mem_we, arb_owner;
  logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata;

  risc_v_mike_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_stall  (core_stall),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_lock    (dma_lock),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_gnt     (dma_gnt),
    .dma_rvalid  (dma_rvalid),
    .dma_rdata   (dma_rdata),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .arb_owner   (arb_owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: owner of the last grant (0 core, 1 DMA), length of the
  // current contended run, pending read and the data each port last received.
  int          m_last;
  int          m_burst;
  bit          m_pend;
  int          m_pend_owner;
  logic [31:0] m_core_rdata, m_dma_rdata, m_addr, m_wdata;
  int          last_g;

  int          n_dma;
  bit          seen_core;
  logic        exp_core[4];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last       = 1;
    m_burst      = 0;
    m_pend       = 1'b0;
    m_pend_owner = 0;
    m_core_rdata = 32'd0;
    m_dma_rdata  = 32'd0;
    m_addr       = 32'd0;
    m_wdata      = 32'd0;
    last_g       = -1;
  endtask

  // Compare every output with the model for the current cycle, then advance
  // the model as if the clock edge had happened.
  task automatic model_check_update();
    int          g;
    int          other;
    logic        we;
    logic [31:0] a, w;
    if (core_req && !dma_req)      g = 0;
    else if (dma_req && !core_req) g = 1;
    else if (core_req && dma_req) begin
      if (m_last == 1 && dma_lock && m_burst < MAX_BURST - 1) g = 1;
      else                                                    g = 1 - m_last;
    end else g = -1;
    we = (g == 1) ? dma_we : core_we;
    a  = (g == 1) ? dma_addr : core_addr;
    w  = (g == 1) ? dma_wdata : core_wdata;

    check_val("core_gnt",    32'(core_gnt),    32'(g == 0));
    check_val("dma_gnt",     32'(dma_gnt),     32'(g == 1));
    check_val("core_stall",  32'(core_stall),  32'(core_req && g != 0));
    check_val("mem_re",      32'(mem_re),      32'(g >= 0 && !we));
    check_val("mem_we",      32'(mem_we),      32'(g >= 0 && we));
    check_val("mem_addr",    mem_addr,         (g >= 0) ? a : m_addr);
    check_val("mem_wdata",   mem_wdata,        (g >= 0) ? w : m_wdata);
    check_val("core_rvalid", 32'(core_rvalid), 32'(m_pend && m_pend_owner == 0));
    check_val("dma_rvalid",  32'(dma_rvalid),  32'(m_pend && m_pend_owner == 1));
    check_val("core_rdata",  core_rdata, (m_pend && m_pend_owner == 0) ? mem_rdata : m_core_rdata);
    check_val("dma_rdata",   dma_rdata,  (m_pend && m_pend_owner == 1) ? mem_rdata : m_dma_rdata);
    check_val("arb_owner",   32'(arb_owner),   32'(m_last));

    if (m_pend) begin
      if (m_pend_owner == 0) m_core_rdata = mem_rdata;
      else                   m_dma_rdata  = mem_rdata;
    end
    if (g >= 0) begin
      other = (g == 0) ? int'(dma_req) : int'(core_req);
      if (g == m_last && other != 0) m_burst = (m_burst < MAX_BURST - 1) ? m_burst + 1 : m_burst;
      else                           m_burst = 0;
      m_last       = g;
      m_pend       = !we;
      m_pend_owner = g;
      m_addr       = a;
      m_wdata      = w;
    end else begin
      m_burst = 0;
      m_pend  = 1'b0;
    end
    last_g = g;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    model_check_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    finish_cycle();
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    core_req   = 1'b0; core_we  = 1'b0; core_addr = 32'd0; core_wdata = 32'd0;
    dma_req    = 1'b0; dma_we   = 1'b0; dma_lock  = 1'b0;
    dma_addr   = 32'd0; dma_wdata = 32'd0; mem_rdata = 32'd0;
    model_reset();
    settle();
    check_val("rst_core_gnt",    32'(core_gnt),    32'd0);
    check_val("rst_dma_gnt",     32'(dma_gnt),     32'd0);
    check_val("rst_core_rvalid", 32'(core_rvalid), 32'd0);
    check_val("rst_dma_rvalid",  32'(dma_rvalid),  32'd0);
    check_val("rst_mem_re",      32'(mem_re),      32'd0);
    check_val("rst_mem_we",      32'(mem_we),      32'd0);
    check_val("rst_core_rdata",  core_rdata,       32'd0);
    check_val("rst_dma_rdata",   dma_rdata,        32'd0);
    check_val("rst_arb_owner",   32'(arb_owner),   32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic new_core_req();
    core_req   = 1'b1;
    core_we    = 1'($urandom_range(0, 1));
    core_addr  = $urandom & 32'hFFFF_FFFC;
    core_wdata = $urandom;
  endtask

  task automatic new_dma_req();
    dma_req   = 1'b1;
    dma_we    = 1'($urandom_range(0, 1));
    dma_addr  = $urandom & 32'hFFFF_FFFC;
    dma_wdata = $urandom;
  endtask

  initial begin
    #2;
    // Single core read and its return.
    do_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0040_0000; mem_rdata = 32'h1234_5678;
    settle();
    check_val("t1_core_gnt", 32'(core_gnt), 32'd1);
    check_val("t1_mem_re",   32'(mem_re),   32'd1);
    check_val("t1_mem_addr", mem_addr,      32'h0040_0000);
    finish_cycle();
    core_req = 1'b0; mem_rdata = 32'hCAFE_0001;
    settle();
    check_val("t1_core_rvalid", 32'(core_rvalid), 32'd1);
    check_val("t1_core_rdata",  core_rdata,       32'hCAFE_0001);
    check_val("t1_dma_rvalid",  32'(dma_rvalid),  32'd0);
    check_val("t1_dma_rdata",   dma_rdata,        32'd0);
    finish_cycle();

    // Contention straight out of reset alternates, core first.
    do_reset();
    exp_core = '{1'b1, 1'b0, 1'b1, 1'b0};
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_0100;
    dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = $urandom;
      settle();
      check_val("t2_core_gnt",   32'(core_gnt),   32'(exp_core[i]));
      check_val("t2_core_stall", 32'(core_stall), 32'(!exp_core[i]));
      finish_cycle();
      if (last_g == 0) core_addr = core_addr + 32'd4;
      else if (last_g == 1) dma_addr = dma_addr + 32'd4;
    end

    // Locked DMA write burst against a waiting core.
    do_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_1000;
    dma_req  = 1'b1; dma_we  = 1'b1; dma_lock  = 1'b1; dma_addr = 32'h0000_2000; dma_wdata = 32'h5555_0000;
    for (int run = 0; run < 2; run++) begin
      n_dma = 0; seen_core = 1'b0;
      for (int i = 0; i < 20 && !seen_core; i++) begin
        mem_rdata = $urandom;
        settle();
        if (core_gnt) seen_core = 1'b1;
        else if (dma_gnt) n_dma++;
        finish_cycle();
        if (last_g == 1) begin dma_addr = dma_addr + 32'd4; dma_wdata = dma_wdata + 32'd1; end
        else if (last_g == 0) core_addr = core_addr + 32'd4;
      end
      // First run starts with the counter clear; later runs begin with the
      // round-robin grant after the core, then the full locked run.
      check_val("t3_lock_run_len", 32'(n_dma), (run == 0) ? 32'(MAX_BURST - 1) : 32'(MAX_BURST));
      check_val("t3_core_won",     32'(seen_core), 32'd1);
    end

    // Reset while a DMA read is in flight.
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_3000; mem_rdata = 32'h0;
    settle();
    check_val("t4_dma_gnt", 32'(dma_gnt), 32'd1);
    finish_cycle();
    rst = 1'b0; dma_req = 1'b0; mem_rdata = 32'h9999_9999;
    model_reset();
    #1;
    check_val("t4_dma_rvalid_rst", 32'(dma_rvalid), 32'd0);
    check_val("t4_dma_rdata_rst",  dma_rdata,       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    settle();
    check_val("t4_arb_owner", 32'(arb_owner),  32'd1);
    check_val("t4_dma_rvalid", 32'(dma_rvalid), 32'd0);
    finish_cycle();

    // Back-to-back core read then DMA read.
    do_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0000_4000; mem_rdata = 32'h0;
    tick();
    core_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_5000; mem_rdata = 32'hAAAA_0001;
    settle();
    check_val("t5_core_rvalid", 32'(core_rvalid), 32'd1);
    check_val("t5_core_rdata",  core_rdata,       32'hAAAA_0001);
    check_val("t5_dma_gnt",     32'(dma_gnt),     32'd1);
    finish_cycle();
    dma_req = 1'b0; mem_rdata = 32'hBBBB_0002;
    settle();
    check_val("t5_dma_rvalid",  32'(dma_rvalid),  32'd1);
    check_val("t5_dma_rdata",   dma_rdata,        32'hBBBB_0002);
    check_val("t5_core_rvalid2", 32'(core_rvalid), 32'd0);
    check_val("t5_core_rdata2", core_rdata,       32'hAAAA_0001);
    finish_cycle();

    // Core write only.
    do_reset();
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h1001_0000; core_wdata = 32'hDEAD_BEEF;
    settle();
    check_val("t6_mem_we",    32'(mem_we),  32'd1);
    check_val("t6_mem_wdata", mem_wdata,    32'hDEAD_BEEF);
    check_val("t6_mem_addr",  mem_addr,     32'h1001_0000);
    finish_cycle();
    core_req = 1'b0; mem_rdata = 32'h7777_7777;
    settle();
    check_val("t6_mem_we_off",  32'(mem_we),      32'd0);
    check_val("t6_core_rvalid", 32'(core_rvalid), 32'd0);
    finish_cycle();

    // Randomized traffic; requests are held until granted.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      mem_rdata = $urandom;
      dma_lock  = 1'($urandom_range(0, 1));
      tick();
      if (last_g == 0 || !core_req) begin
        if ($urandom_range(0, 99) < 60) new_core_req();
        else core_req = 1'b0;
      end
      if (last_g == 1 || !dma_req) begin
        if ($urandom_range(0, 99) < 60) new_dma_req();
        else dma_req = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
